// File: rtl/sram_controller.sv
// Memory-stage controller for a 16-bit asynchronous SRAM: each 32-bit load/store
// is split into a low and a high half-word phase, and the pipeline is held frozen until the access completes.
module sram_controller #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned     CNT_W    = $clog2(PHASE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [17:0]     BASE_LO  = 18'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_is_wr;
    logic [17:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               w_req;
    logic               w_last;
    logic               w_active;
    logic               w_hi;
    logic [17:0]        w_off;
    logic               w_dq_oe;
    logic [15:0]        w_dq_out;
    logic               w_unused;

    assign w_req  = wr_en | rd_en;
    assign w_last = (r_cnt == CNT_LAST);
    // Only the low 18 bits of the offset reach the SRAM, so the subtraction is done at that width.
    assign w_off  = r_addr - BASE_LO;
    assign w_unused = ^{address[31:18], w_off[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next     = S_LOW;
                    w_cnt_next = '0;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_next     = S_HIGH;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_next     = S_DONE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so reset releases the bus immediately.
    always_comb begin
        w_active  = (r_state == S_LOW) || (r_state == S_HIGH);
        w_hi      = (r_state == S_HIGH);
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = w_hi ? r_wdata[31:16] : r_wdata[15:0];
        if (w_active) begin
            SRAM_ADDR = {1'b0, w_off[17:2], w_hi};
            SRAM_WE_N = ~r_is_wr;
            SRAM_OE_N = r_is_wr;
            w_dq_oe   = r_is_wr;
        end
    end

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready     = ~w_req | (r_state == S_DONE);
    assign read_data = r_rdata;

    // Request latch and read-half capture; a simultaneous wr_en/rd_en is a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_req) begin
                r_is_wr <= wr_en;
                r_addr  <= address[17:0];
                r_wdata <= write_data;
            end
            if ((r_state == S_LOW) && w_last && !r_is_wr) begin
                r_rdata[15:0] <= SRAM_DQ;
            end
            if ((r_state == S_HIGH) && w_last && !r_is_wr) begin
                r_rdata[31:16] <= SRAM_DQ;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a half-word SRAM model on the bus.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] SRAM_DQ;
    wire  [17:0] SRAM_ADDR;
    wire         SRAM_WE_N;
    wire         SRAM_OE_N;
    wire         SRAM_CE_N;
    wire         SRAM_UB_N;
    wire         SRAM_LB_N;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [17:0] exp_sa;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] sb_q [$];

    logic [15:0] mem [0:255];
    logic        mem_clr = 1'b1;
    logic        probe_en = 1'b0;

    sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // SRAM model: drives on read, stores on write; probe_en forces a marker to prove the DUT is off the bus.
    assign SRAM_DQ = probe_en ? 16'h5A3C :
                     ((!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz);

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 0x%08h expected a queued value", name, read_data);
        end else begin
            e = sb_q.pop_front();
            chk(name, read_data, e);
        end
    endtask

    // Drive one request from IDLE (called #1 after a posedge) and check it through DONE.
    task automatic run_access(input vec_t v, input int idx);
        bit done = 1'b0;
        bit is_wr = v.wr;
        wr_en = v.wr;
        rd_en = v.rd;
        address = v.addr;
        write_data = v.wdata;
        if (!is_wr) sb_q.push_back(v.exp_rd);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk($sformatf("v%0d_sa_lo", idx), 32'(SRAM_ADDR), 32'(v.exp_sa));
                chk($sformatf("v%0d_we_n", idx), 32'(SRAM_WE_N), 32'(!is_wr));
                chk($sformatf("v%0d_oe_n", idx), 32'(SRAM_OE_N), 32'(is_wr));
            end
            if (cyc == 4) chk($sformatf("v%0d_sa_hi", idx), 32'(SRAM_ADDR), 32'(v.exp_sa) + 32'd1);
            if (ready) begin
                done = 1'b1;
                chk($sformatf("v%0d_ready_low_cycles", idx), 32'(cyc), 32'd7);
                chk($sformatf("v%0d_done_sa", idx), 32'(SRAM_ADDR), 32'd0);
                if (!is_wr) pop_chk($sformatf("v%0d_read_data", idx));
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout: ready stayed 0 for 20 cycles, expected 1 in cycle 7", idx);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (is_wr) begin
            chk($sformatf("v%0d_mem_lo", idx), 32'(mem[v.exp_sa[7:0]]), 32'(v.wdata[15:0]));
            chk($sformatf("v%0d_mem_hi", idx), 32'(mem[v.exp_sa[7:0] + 8'd1]), 32'(v.wdata[31:16]));
        end
    endtask

    initial begin
        int d1;
        int d2;
        int we_low;

        vecs[0] = '{1'b1, 1'b0, 32'd1024,              32'hDEADBEEF, 32'h0,        18'd0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,              32'h0,        32'hDEADBEEF, 18'd0};
        vecs[2] = '{1'b1, 1'b0, 32'd1044,              32'hCAFEF00D, 32'h0,        18'd10};
        vecs[3] = '{1'b0, 1'b1, 32'd1047,              32'h0,        32'hCAFEF00D, 18'd10};
        vecs[4] = '{1'b1, 1'b1, 32'd1032,              32'h12345678, 32'h0,        18'd4};
        vecs[5] = '{1'b0, 1'b1, 32'd1032,              32'h0,        32'h12345678, 18'd4};
        vecs[6] = '{1'b1, 1'b0, 32'd1024 + 32'h40008,  32'hA5A55A5A, 32'h0,        18'd4};
        vecs[7] = '{1'b0, 1'b1, 32'd1032,              32'h0,        32'hA5A55A5A, 18'd4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("tie_offs", 32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // Back-to-back read then write with the request never dropping.
        d1 = -1;
        d2 = -1;
        rd_en = 1'b1;
        address = 32'd1044;
        sb_q.push_back(32'hCAFEF00D);
        for (int c = 0; c < 30 && d2 < 0; c++) begin
            @(negedge clk);
            if (ready) begin
                if (d1 < 0) begin
                    d1 = c;
                    pop_chk("b2b_read_data");
                end else begin
                    d2 = c;
                end
            end
            @(posedge clk);
            #1;
            if (c == d1) begin
                rd_en = 1'b0;
                wr_en = 1'b1;
                address = 32'd1048;
                write_data = 32'h11112222;
            end
        end
        wr_en = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd7);
        chk("b2b_done_gap", 32'(d2 - d1), 32'd8);
        chk("b2b_read_kept", read_data, 32'hCAFEF00D);
        chk("b2b_mem_lo", 32'(mem[12]), 32'h2222);
        chk("b2b_mem_hi", 32'(mem[13]), 32'h1111);
        @(posedge clk);
        #1;

        // Flush: wr_en dropped from cycle 2; access must still finish, DONE in cycle 7.
        we_low = 0;
        wr_en = 1'b1;
        address = 32'd1056;
        write_data = 32'h0BAD0CAD;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!SRAM_WE_N) we_low++;
            if (c == 7) chk("flush_done_c7", 32'(ready), 32'd1);
            @(posedge clk);
            #1;
            if (c == 1) wr_en = 1'b0;
            if (c == 6) rd_en = 1'b1;
            if (c == 7) rd_en = 1'b0;
        end
        chk("flush_we_low_cycles", 32'(we_low), 32'd6);
        chk("flush_mem_lo", 32'(mem[16]), 32'h0CAD);
        chk("flush_mem_hi", 32'(mem[17]), 32'h0BAD);
        chk("flush_read_kept", read_data, 32'hCAFEF00D);
        @(posedge clk);
        #1;

        // Reset in cycle 4 of a write.
        wr_en = 1'b1;
        address = 32'd1064;
        write_data = 32'h77778888;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("mid_rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("mid_rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("mid_rst_read_data", read_data, 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        probe_en = 1'b1;
        #1;
        chk("mid_rst_dq_released", 32'(SRAM_DQ), 32'h5A3C);
        probe_en = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_access(vecs[1], 8);
        chk("mid_rst_mem_lo", 32'(mem[20]), 32'h8888);
        chk("mid_rst_mem_hi_untouched", 32'(mem[21]), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences the off-chip 16-bit SRAM on behalf of the pipeline's memory stage. It accepts one 32-bit word read or write per request, using the ALU result as address and the forwarded Rm value as write data. It performs the access as two 16-bit SRAM phases with fixed wait states. While the access is in flight it holds `ready` low so the hazard/freeze logic stalls every pipeline register upstream of MEM.

## Interface

Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0; subtracted from `address`.
- `PHASE_CYCLES`, 3: cycles each 16-bit half-access is held on the bus (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request (MEM-stage `mem_write_en`).
- `rd_en`  in  1  read request (MEM-stage `mem_read_en`).
- `address`  in  32  byte address (ALU result); bits [1:0] ignored.
- `write_data`  in  32  store data (forwarded Rm).
- `read_data`  out  32  registered load data.
- `ready`  out  1  combinational: 0 = freeze pipeline.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  write strobe, active low.
- `SRAM_OE_N`  out  1  output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1  each tied 0.

## Operation

- States: IDLE, LOW, HIGH, DONE. A phase counter of width clog2(PHASE_CYCLES)+1 counts within LOW and HIGH.
- IDLE with `wr_en|rd_en`=1: on the next edge the controller latches the operation, `address` and `write_data`, then enters LOW with counter=0.
  - `wr_en`=`rd_en`=1 is treated as a write.
- LOW: `SRAM_ADDR` = {off[17:2], 1'b0}, where off = latched address − BASE_ADDR (32-bit, modulo 2^32).
- HIGH: `SRAM_ADDR` = {off[17:2], 1'b1}. Upper bits of off are discarded (wrap-around).
- Each phase lasts exactly PHASE_CYCLES cycles. After the last cycle, LOW goes to HIGH and HIGH goes to DONE.
- Write phases:
  - `SRAM_WE_N`=0 and `SRAM_OE_N`=1.
  - `SRAM_DQ` is driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Read phases:
  - `SRAM_WE_N`=1, `SRAM_OE_N`=0, `SRAM_DQ` high-Z.
  - On the last cycle of LOW, `SRAM_DQ` is captured into read_data[15:0]; on the last cycle of HIGH, into read_data[31:16].
  - Captures happen at the clock edge ending that cycle.
  - `read_data` holds its value until the next read overwrites it; writes never change it.
- DONE lasts one cycle, then IDLE unconditionally.
- In IDLE and DONE: `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0.
- `ready` = ~(wr_en|rd_en) | (state==DONE).
- Request deasserted mid-access (flush): the access runs to completion. No abort is permitted, so a partial write never occurs.
- Back-to-back accesses: a request present in the cycle after DONE (new instruction) starts a fresh access from IDLE.

## Timing

- Request first seen in cycle 0 (IDLE): `ready`=0 in cycles 0 … 2·PHASE_CYCLES; `ready`=1 in cycle 2·PHASE_CYCLES+1 (DONE).
  - With the default: LOW cycles 1–3, HIGH 4–6, DONE 7, so `ready` is low for 7 cycles.
- Load data is valid in `read_data` from the DONE cycle onward, when the pipeline register samples it.
- No request: `ready`=1 with zero latency; the controller stays in IDLE.
- `rst_n`=0 at any time, including mid-write, immediately forces:
  - state IDLE, counter 0, `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z;
  - `ready` follows its combinational equation with state=IDLE.
- Release of `rst_n` is synchronous to the first following `clk` edge. An access requested in that cycle starts normally.

## Test plan

- Write 0xDEADBEEF to address 1024, then read 1024:
  - half-word SRAM model holds 0xBEEF at 0 and 0xDEAD at 1;
  - read returns 0xDEADBEEF in DONE;
  - `ready` low exactly 7 cycles per access.
- Address 1024+4·5 = 1044: LOW drives `SRAM_ADDR`=10, HIGH drives 11; `address`[1:0]=2'b11 gives the same result.
- Back-to-back read then write with requests held continuously: two DONE pulses 8 cycles apart; `read_data` unchanged by the write.
- Drop `wr_en` in cycle 2 of an access: both halves still written; DONE still in cycle 7.
- Assert `rst_n`=0 in cycle 4 of a write: `SRAM_WE_N`=1 and `SRAM_DQ` high-Z in the same cycle, `read_data`=0; after release, a new read completes normally.
- `wr_en`=`rd_en`=1 with data 0x12345678: performs a write; the SRAM model contains 0x5678/0x1234.
